// File: rtl/mem_port_arbiter_if.sv
// Request/grant and memory-side bundle shared by the fetch stage, the LS stage and the memory port.
// The slave modport is the arbiter's view. The master modport is the surrounding environment.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          ls_req;
  logic          ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_gnt;
  logic          ls_rvalid;
  logic [DW-1:0] ls_rdata;

  logic          mem_ren;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    output mem_ren, mem_wen, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    input  mem_ren, mem_wen, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, with one command in flight at a time.
// The optional IF anti-starvation counter is enabled by defining MEM_ARB_STARVE_EN.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);

  state_t        state_q;
  logic          owner_ls_q;
  logic          we_q;
  logic [2:0]    lat_cnt_q;
  logic          mem_ren_q;
  logic          mem_wen_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          if_gnt_q;
  logic          ls_gnt_q;
  logic          if_rvalid_q;
  logic          ls_rvalid_q;
  logic          busy_q;

  logic          any_req_d;
  logic          ls_wins_d;

  assign any_req_d = bus.if_req | bus.ls_req;

`ifdef MEM_ARB_STARVE_EN
  logic [2:0] starve_cnt_q;
  logic [2:0] starve_cnt_d;

  // LS loses a contested arbitration only once IF has lost STARVE_MAX in a row.
  always_comb begin
    ls_wins_d    = bus.ls_req && !(bus.if_req && (starve_cnt_q == 3'(STARVE_MAX)));
    starve_cnt_d = starve_cnt_q;
    if ((state_q == IDLE) && any_req_d) begin
      if (!ls_wins_d) begin
        starve_cnt_d = '0;
      end else if (bus.if_req && (starve_cnt_q != 3'(STARVE_MAX))) begin
        starve_cnt_d = starve_cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign ls_wins_d = bus.ls_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_ls_q  <= 1'b0;
      we_q        <= 1'b0;
      lat_cnt_q   <= '0;
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req_d) begin
            state_q    <= ISSUE;
            busy_q     <= 1'b1;
            owner_ls_q <= ls_wins_d;
            if (ls_wins_d) begin
              mem_addr_q  <= bus.ls_addr;
              mem_wdata_q <= bus.ls_wdata;
              we_q        <= bus.ls_we;
              mem_ren_q   <= !bus.ls_we;
              mem_wen_q   <= bus.ls_we;
              ls_gnt_q    <= 1'b1;
            end else begin
              mem_addr_q  <= bus.if_addr;
              we_q        <= 1'b0;
              mem_ren_q   <= 1'b1;
              if_gnt_q    <= 1'b1;
            end
          end
        end
        ISSUE: begin
          lat_cnt_q <= LAT_INIT;
          if (we_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= WAIT;
            // With a one-cycle latency the only WAIT cycle already carries the data.
            if (RD_LAT == 1) begin
              if_rvalid_q <= !owner_ls_q;
              ls_rvalid_q <= owner_ls_q;
            end
          end
        end
        WAIT: begin
          if (lat_cnt_q == 3'd0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            lat_cnt_q <= lat_cnt_q - 3'd1;
            if (lat_cnt_q == 3'd1) begin
              if_rvalid_q <= !owner_ls_q;
              ls_rvalid_q <= owner_ls_q;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_ren   = mem_ren_q;
  assign bus.mem_wen   = mem_wen_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_gnt    = if_gnt_q;
  assign bus.ls_gnt    = ls_gnt_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.ls_rvalid = ls_rvalid_q;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.ls_rdata  = bus.mem_rdata;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: unit A uses RD_LAT=1 and unit B uses RD_LAT=3.
// The starvation expectations follow MEM_ARB_STARVE_EN.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(32), .DW(32)) a_if ();
  mem_port_arbiter_if #(.AW(32), .DW(32)) b_if ();

  mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .STARVE_MAX(4)) u_a (
    .clk (clk),
    .rst (rst_a),
    .bus (a_if.slave)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(3), .STARVE_MAX(4)) u_b (
    .clk (clk),
    .rst (rst_b),
    .bus (b_if.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    int ls_cnt;
    int if_cnt;
    int ls_before_if;
    int both_cnt;

    a_if.if_req = 1'b0; a_if.if_addr = '0; a_if.ls_req = 1'b0; a_if.ls_we = 1'b0;
    a_if.ls_addr = '0; a_if.ls_wdata = '0; a_if.mem_rdata = '0;
    b_if.if_req = 1'b0; b_if.if_addr = '0; b_if.ls_req = 1'b0; b_if.ls_we = 1'b0;
    b_if.ls_addr = '0; b_if.ls_wdata = '0; b_if.mem_rdata = '0;

    // Reset is held with both requests pending, and nothing may come out.
    a_if.if_req = 1'b1; a_if.if_addr = 32'h100;
    a_if.ls_req = 1'b1; a_if.ls_we = 1'b0; a_if.ls_addr = 32'h80;
    repeat (3) cyc();
    chk("rst_if_gnt", a_if.if_gnt, 0);
    chk("rst_ls_gnt", a_if.ls_gnt, 0);
    chk("rst_mem_ren", a_if.mem_ren, 0);
    chk("rst_mem_wen", a_if.mem_wen, 0);
    chk("rst_busy", a_if.busy, 0);
    chk("rst_mem_addr", a_if.mem_addr, 0);
    chk("rst_if_rvalid", a_if.if_rvalid, 0);
    chk("rst_ls_rvalid", a_if.ls_rvalid, 0);
    rst_a = 1'b1;

    // A simultaneous request goes to LS first, here as a load from 0x80.
    cyc();
    chk("sim_ls_gnt", a_if.ls_gnt, 1);
    chk("sim_if_gnt0", a_if.if_gnt, 0);
    chk("sim_ren", a_if.mem_ren, 1);
    chk("sim_wen", a_if.mem_wen, 0);
    chk("sim_addr", a_if.mem_addr, 32'h80);
    chk("sim_busy", a_if.busy, 1);
    a_if.ls_req = 1'b0;
    a_if.mem_rdata = 32'hCAFEF00D;
    cyc();
    chk("ld_ls_rvalid", a_if.ls_rvalid, 1);
    chk("ld_ls_rdata", a_if.ls_rdata, 32'hCAFEF00D);
    chk("ld_if_rvalid0", a_if.if_rvalid, 0);
    chk("ld_ren_off", a_if.mem_ren, 0);
    chk("ld_if_gnt_wait", a_if.if_gnt, 0);
    cyc();
    chk("ld_idle_busy", a_if.busy, 0);
    chk("ld_rvalid_pulse", a_if.ls_rvalid, 0);
    chk("ld_if_gnt_idle", a_if.if_gnt, 0);

    // IF is served in the next IDLE cycle with a read from 0x100.
    cyc();
    chk("if_gnt", a_if.if_gnt, 1);
    chk("if_ls_gnt0", a_if.ls_gnt, 0);
    chk("if_ren", a_if.mem_ren, 1);
    chk("if_addr", a_if.mem_addr, 32'h100);
    a_if.if_req = 1'b0;
    a_if.mem_rdata = 32'hDEADBEEF;
    cyc();
    chk("if_rvalid", a_if.if_rvalid, 1);
    chk("if_rdata", a_if.if_rdata, 32'hDEADBEEF);
    chk("if_ls_rvalid0", a_if.ls_rvalid, 0);
    cyc();
    chk("if_rvalid_pulse", a_if.if_rvalid, 0);
    chk("if_busy_done", a_if.busy, 0);

    // An LS store is followed by an IF request that is raised and dropped without being granted.
    a_if.ls_req = 1'b1; a_if.ls_we = 1'b1; a_if.ls_addr = 32'h40; a_if.ls_wdata = 32'h12345678;
    cyc();
    chk("st_wen", a_if.mem_wen, 1);
    chk("st_ren0", a_if.mem_ren, 0);
    chk("st_addr", a_if.mem_addr, 32'h40);
    chk("st_wdata", a_if.mem_wdata, 32'h12345678);
    chk("st_ls_gnt", a_if.ls_gnt, 1);
    chk("st_busy", a_if.busy, 1);
    a_if.ls_req = 1'b0;
    a_if.if_req = 1'b1; a_if.if_addr = 32'h180;
    cyc();
    chk("st_wen_pulse", a_if.mem_wen, 0);
    chk("st_no_rvalid", a_if.ls_rvalid, 0);
    chk("st_busy_low", a_if.busy, 0);
    chk("st_if_ignored", a_if.if_gnt, 0);
    a_if.if_req = 1'b0;
    cyc();
    chk("drop_no_ren", a_if.mem_ren, 0);
    chk("drop_no_gnt", a_if.if_gnt, 0);
    chk("drop_no_rvalid", a_if.ls_rvalid, 0);

    // LS stores are requested continuously while IF also requests.
    ls_cnt = 0; if_cnt = 0; ls_before_if = -1; both_cnt = 0;
    a_if.ls_req = 1'b1; a_if.ls_we = 1'b1; a_if.ls_addr = 32'h44; a_if.ls_wdata = 32'h55AA55AA;
    a_if.if_req = 1'b1; a_if.if_addr = 32'h1C0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (a_if.ls_gnt && a_if.if_gnt) both_cnt++;
      if (a_if.ls_gnt) ls_cnt++;
      if (a_if.if_gnt) begin
        if_cnt++;
        ls_before_if = ls_cnt;
        a_if.if_req = 1'b0;
      end
    end
    a_if.ls_req = 1'b0;
    a_if.if_req = 1'b0;
    chk("starve_both_gnt", both_cnt, 0);
`ifdef MEM_ARB_STARVE_EN
    chk("starve_if_cnt", if_cnt, 1);
    chk("starve_ls_before", ls_before_if, 4);
`else
    chk("strict_if_cnt", if_cnt, 0);
    chk("strict_ls_cnt", ls_cnt, 10);
`endif
    repeat (4) cyc();
    chk("starve_idle", a_if.busy, 0);

    // Unit B runs a full read with RD_LAT=3 from 0x200.
    rst_b = 1'b1;
    b_if.if_req = 1'b1; b_if.if_addr = 32'h200;
    cyc();
    chk("l3_gnt", b_if.if_gnt, 1);
    chk("l3_ren", b_if.mem_ren, 1);
    chk("l3_addr", b_if.mem_addr, 32'h200);
    b_if.if_req = 1'b0;
    cyc();
    chk("l3_w1_rvalid", b_if.if_rvalid, 0);
    chk("l3_w1_busy", b_if.busy, 1);
    chk("l3_w1_ren", b_if.mem_ren, 0);
    cyc();
    chk("l3_w2_rvalid", b_if.if_rvalid, 0);
    b_if.mem_rdata = 32'h0BADF00D;
    cyc();
    chk("l3_rvalid", b_if.if_rvalid, 1);
    chk("l3_rdata", b_if.if_rdata, 32'h0BADF00D);
    chk("l3_busy_w3", b_if.busy, 1);
    cyc();
    chk("l3_rvalid_pulse", b_if.if_rvalid, 0);
    chk("l3_busy_done", b_if.busy, 0);

    // An LS load on unit B is cut by reset in its second WAIT cycle.
    b_if.ls_req = 1'b1; b_if.ls_we = 1'b0; b_if.ls_addr = 32'h300;
    cyc();
    chk("l3r_ls_gnt", b_if.ls_gnt, 1);
    b_if.ls_req = 1'b0;
    cyc();
    cyc();
    chk("l3r_busy_pre", b_if.busy, 1);
    rst_b = 1'b0;
    #1;
    chk("l3r_busy_async", b_if.busy, 0);
    chk("l3r_addr_async", b_if.mem_addr, 0);
    cyc();
    chk("l3r_no_rvalid", b_if.ls_rvalid, 0);
    chk("l3r_busy", b_if.busy, 0);
    rst_b = 1'b1;
    cyc();
    chk("l3r_no_rvalid2", b_if.ls_rvalid, 0);
    chk("l3r_no_gnt", b_if.ls_gnt, 0);
    chk("l3r_idle", b_if.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
